// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator
//   Counts the ones in each accepted 3-bit sample (a, b, c) and accumulates
//   them over a frame of FRAME_LEN accepted samples. When the frame ends, the
//   total and a majority flag are held on the outputs until the consumer acks.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : begin a frame (taken in IDLE, or in DONE together with ack)
//   in_valid    : a/b/c carry a sample (taken in ACC only)
//   a, b, c     : sample bits 2..0
//   ack         : consumer has taken the result (taken in DONE only)
//   busy        : frame in progress or result pending
//   pop_q       : ones-count of the last accepted sample
//   sum         : running / final ones total, saturating
//   done        : result valid, held until ack
//   maj         : 1 iff 2*sum > 3*FRAME_LEN, valid while done
module ones_frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 5,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             ack,
    output logic             busy,
    output logic [1:0]       pop_q,
    output logic [SUM_W-1:0] sum,
    output logic             done,
    output logic             maj
);
    // One spare bit so 2*sum and 3*FRAME_LEN can never overflow the compare.
    localparam int LOG_THR = $clog2(3 * FRAME_LEN);
    localparam int MAJ_W   = ((SUM_W > LOG_THR) ? SUM_W : LOG_THR) + 1;
    localparam logic [MAJ_W-1:0] MAJ_THR = MAJ_W'(3 * FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SUM_W-1:0] sum_nxt, sum_add;
    logic [SUM_W:0]   sum_wide;
    logic [MAJ_W-1:0] sum_ext;
    logic [1:0]       pop, pop_nxt;
    logic             maj_cmp, maj_nxt, done_nxt, busy_nxt;

    assign pop      = {1'b0, a} + {1'b0, b} + {1'b0, c};
    assign sum_wide = {1'b0, sum} + (SUM_W + 1)'(pop);
    // Carry out of the accumulator pins the total at all-ones.
    assign sum_add  = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    // Majority looks at the total including the sample being accepted.
    assign sum_ext  = MAJ_W'(sum_add);
    assign maj_cmp  = (sum_ext << 1) > MAJ_THR;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sum_nxt   = sum;
        pop_nxt   = pop_q;
        maj_nxt   = maj;
        done_nxt  = done;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACC;
                    cnt_nxt   = '0;
                    sum_nxt   = '0;
                    pop_nxt   = '0;
                    maj_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ACC: begin
                if (in_valid) begin
                    sum_nxt = sum_add;
                    pop_nxt = pop;
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        maj_nxt   = maj_cmp;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    done_nxt = 1'b0;
                    if (start) begin
                        // Back-to-back frame: skip IDLE, busy stays high.
                        state_nxt = ACC;
                        sum_nxt   = '0;
                        pop_nxt   = '0;
                        maj_nxt   = 1'b0;
                    end else begin
                        // Total stays visible in IDLE until the next start.
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
            pop_q <= '0;
            maj   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sum   <= sum_nxt;
            pop_q <= pop_nxt;
            maj   <= maj_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end
endmodule
